branch_predictor: RTL and testbench

Parametrised dynamic branch predictor replacing the static not-taken scheme in the pipelined RV32I datapath. It is looked up combinationally with the IF-stage PC and predicts direction and target. Direction comes from a gshare table of saturating counters (PC xor global history). Target comes from a direct-mapped BTB. It is trained from the EX stage when a branch or jump resolves, and it keeps lookup and mispredict statistics counters.

---
 rtl/branch_predictor.sv | 132 +++++++++++++
 tb/tb_branch_predictor.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: gshare direction table of saturating counters plus a
// direct-mapped BTB for targets. Looked up combinationally from the IF-stage PC,
// trained non-speculatively from EX at resolution time, with lookup/mispredict stats.
module branch_predictor #(
   parameter int BHT_IDX_BITS = 6,
   parameter int GHR_BITS     = 6,
   parameter int CNT_BITS     = 2,
   parameter int BTB_IDX_BITS = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall,
   input  logic                    lookup_valid,
   input  logic [31:0]             pc_if,
   output logic                    pred_taken,
   output logic [31:0]             pred_target,
   output logic                    btb_hit,
   output logic [BHT_IDX_BITS-1:0] pred_idx,
   input  logic                    upd_valid,
   input  logic                    upd_is_br,
   input  logic [31:0]             upd_pc,
   input  logic [BHT_IDX_BITS-1:0] upd_idx,
   input  logic                    upd_taken,
   input  logic [31:0]             upd_target,
   input  logic                    upd_mispredict,
   output logic [31:0]             stat_lookups,
   output logic [31:0]             stat_mispredicts
);

   localparam int BHT_N = 1 << BHT_IDX_BITS;
   localparam int BTB_N = 1 << BTB_IDX_BITS;
   localparam int TAG_W = 30 - BTB_IDX_BITS;
   localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

   logic [CNT_BITS-1:0] cnt_q       [BHT_N];
   logic                btb_valid_q [BTB_N];
   logic [TAG_W-1:0]    btb_tag_q   [BTB_N];
   logic [31:0]         btb_tgt_q   [BTB_N];
   logic                btb_jal_q   [BTB_N];
   logic [GHR_BITS-1:0] ghr_q, ghr_d, ghr_shift;
   logic [31:0]         stat_lookups_q, stat_lookups_d;
   logic [31:0]         stat_mis_q, stat_mis_d;

   logic [BHT_IDX_BITS-1:0] ghr_ext;
   logic [BHT_IDX_BITS-1:0] lk_idx;
   logic [BTB_IDX_BITS-1:0] lk_btb_idx;
   logic [TAG_W-1:0]        lk_tag;
   logic                    lk_hit;
   logic                    lk_taken;

   logic [BTB_IDX_BITS-1:0] up_btb_idx;
   logic [TAG_W-1:0]        up_tag;
   logic [CNT_BITS-1:0]     cnt_cur, cnt_d;
   logic                    cnt_we, btb_we;

   // Only word-aligned PCs are predicted; the byte-offset bits carry no information.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_if[1:0], upd_pc[1:0]};

   // History shift; a single-bit history simply holds the latest outcome.
   if (GHR_BITS > 1) begin : g_ghr_wide
      assign ghr_shift = {ghr_q[GHR_BITS-2:0], upd_taken};
   end else begin : g_ghr_one
      assign ghr_shift = upd_taken;
   end

   // Lookup path: purely combinational from registered state, so a same-cycle
   // update is not visible until the following cycle.
   always_comb begin
      ghr_ext                 = '0;
      ghr_ext[GHR_BITS-1:0]   = ghr_q;
      lk_idx                  = pc_if[BHT_IDX_BITS+1:2] ^ ghr_ext;
      lk_btb_idx              = pc_if[BTB_IDX_BITS+1:2];
      lk_tag                  = pc_if[31:BTB_IDX_BITS+2];
      lk_hit                  = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
      lk_taken                = lk_hit && (btb_jal_q[lk_btb_idx] || cnt_q[lk_idx][CNT_BITS-1]);
   end

   assign btb_hit          = lk_hit;
   assign pred_taken       = lk_taken;
   assign pred_target      = lk_taken ? btb_tgt_q[lk_btb_idx] : pc_if + 32'd4;
   assign pred_idx         = lk_idx;
   assign stat_lookups     = stat_lookups_q;
   assign stat_mispredicts = stat_mis_q;

   // Training next-state: saturating counter step, history shift, BTB fill, stats.
   always_comb begin
      up_btb_idx = upd_pc[BTB_IDX_BITS+1:2];
      up_tag     = upd_pc[31:BTB_IDX_BITS+2];
      cnt_cur    = cnt_q[upd_idx];
      cnt_d      = cnt_cur;
      if (upd_taken) begin
         if (cnt_cur != CNT_MAX) cnt_d = cnt_cur + CNT_BITS'(1);
      end else begin
         if (cnt_cur != '0) cnt_d = cnt_cur - CNT_BITS'(1);
      end
      cnt_we         = upd_valid && upd_is_br;
      btb_we         = upd_valid && upd_taken;
      ghr_d          = cnt_we ? ghr_shift : ghr_q;
      stat_lookups_d = stat_lookups_q + (lookup_valid ? 32'd1 : 32'd0);
      stat_mis_d     = stat_mis_q + ((upd_valid && upd_mispredict) ? 32'd1 : 32'd0);
   end

   // State registers; stall freezes everything, reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_N; i++) cnt_q[i] <= CNT_INIT;
         for (int i = 0; i < BTB_N; i++) begin
            btb_valid_q[i] <= 1'b0;
            btb_tag_q[i]   <= '0;
            btb_tgt_q[i]   <= '0;
            btb_jal_q[i]   <= 1'b0;
         end
         ghr_q          <= '0;
         stat_lookups_q <= '0;
         stat_mis_q     <= '0;
      end else if (!stall) begin
         if (cnt_we) cnt_q[upd_idx] <= cnt_d;
         if (btb_we) begin
            btb_valid_q[up_btb_idx] <= 1'b1;
            btb_tag_q[up_btb_idx]   <= up_tag;
            btb_tgt_q[up_btb_idx]   <= upd_target;
            btb_jal_q[up_btb_idx]   <= !upd_is_br;
         end
         ghr_q          <= ghr_d;
         stat_lookups_q <= stat_lookups_d;
         stat_mis_q     <= stat_mis_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a behavioural model predicts every
// lookup, the prediction is queued when stimulus is driven and compared when the
// outputs are sampled on the falling edge.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        lookup_valid;
   logic [31:0] pc_if;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        btb_hit;
   logic [5:0]  pred_idx;
   logic        upd_valid;
   logic        upd_is_br;
   logic [31:0] upd_pc;
   logic [5:0]  upd_idx;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_mispredict;
   logic [31:0] stat_lookups;
   logic [31:0] stat_mispredicts;

   int checks = 0;
   int errors = 0;

   branch_predictor #(.BHT_IDX_BITS(6), .GHR_BITS(6), .CNT_BITS(2), .BTB_IDX_BITS(5)) dut (
      .clk(clk), .rst(rst), .stall(stall), .lookup_valid(lookup_valid), .pc_if(pc_if),
      .pred_taken(pred_taken), .pred_target(pred_target), .btb_hit(btb_hit), .pred_idx(pred_idx),
      .upd_valid(upd_valid), .upd_is_br(upd_is_br), .upd_pc(upd_pc), .upd_idx(upd_idx),
      .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
      .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        hit;
      logic        taken;
      logic [31:0] target;
      logic [5:0]  idx;
      logic [31:0] lk;
      logic [31:0] mp;
   } pred_t;

   pred_t exp_q[$];
   pred_t e;

   logic [1:0]  m_cnt [64];
   logic [5:0]  m_ghr;
   logic        m_v   [32];
   logic [24:0] m_tag [32];
   logic [31:0] m_tgt [32];
   logic        m_jal [32];
   logic [31:0] m_look, m_mis;

   task automatic reset_model();
      for (int i = 0; i < 64; i++) m_cnt[i] = 2'b01;
      for (int i = 0; i < 32; i++) begin
         m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_jal[i] = 1'b0;
      end
      m_ghr = '0; m_look = '0; m_mis = '0;
   endtask

   function automatic pred_t model_pred(input logic [31:0] pc);
      pred_t p;
      int b;
      b        = int'(pc[6:2]);
      p.idx    = pc[7:2] ^ m_ghr;
      p.hit    = m_v[b] && (m_tag[b] == pc[31:7]);
      p.taken  = p.hit && (m_jal[b] || m_cnt[p.idx][1]);
      p.target = p.taken ? m_tgt[b] : pc + 32'd4;
      p.lk     = m_look;
      p.mp     = m_mis;
      return p;
   endfunction

   // Apply one cycle of stimulus and queue the predicted lookup result.
   task automatic drive(input logic lv, input logic [31:0] pc, input logic uv, input logic br,
                        input logic [31:0] upc, input logic [5:0] uidx, input logic ut,
                        input logic [31:0] utgt, input logic umis, input logic stl);
      lookup_valid = lv; pc_if = pc; upd_valid = uv; upd_is_br = br; upd_pc = upc;
      upd_idx = uidx; upd_taken = ut; upd_target = utgt; upd_mispredict = umis; stall = stl;
      exp_q.push_back(model_pred(pc));
      @(negedge clk);
   endtask

   // Advance through the rising edge and mirror the architectural update in the model.
   task automatic commit();
      int b;
      @(posedge clk);
      if (!rst && !stall) begin
         if (lookup_valid) m_look++;
         if (upd_valid) begin
            if (upd_mispredict) m_mis++;
            if (upd_is_br) begin
               if (upd_taken && m_cnt[upd_idx] != 2'd3) m_cnt[upd_idx]++;
               else if (!upd_taken && m_cnt[upd_idx] != 2'd0) m_cnt[upd_idx]--;
               m_ghr = {m_ghr[4:0], upd_taken};
            end
            if (upd_taken) begin
               b = int'(upd_pc[6:2]);
               m_v[b] = 1'b1; m_tag[b] = upd_pc[31:7]; m_tgt[b] = upd_target; m_jal[b] = !upd_is_br;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; lookup_valid = 1'b0; pc_if = '0; upd_valid = 1'b0; upd_is_br = 1'b0;
      upd_pc = '0; upd_idx = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
      reset_model();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      drive(1, 32'h4000_0000, 0, 0, 0, 0, 0, 0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if ({btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts} !==
          {1'b0, 1'b0, 32'h4000_0004, 6'h00, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL reset_state: got hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d, want 0 0 40000004 00 0 0",
                  btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts);
      end
      commit();
   endtask

   task automatic test_taken_train();
      logic [5:0] idx0;
      idx0 = model_pred(32'h4000_0010).idx;
      for (int k = 0; k < 11; k++) begin
         if (k < 4) drive(1, 32'h4000_0010, 1, 1, 32'h4000_0010, idx0, 1, 32'h4000_0080, 0, 0);
         else if (k < 10) drive(1, 32'h4000_0300, 1, 1, 32'h4000_0300, 6'h3f, 0, 32'h4000_0999, 1, 0);
         else drive(1, 32'h4000_0010, 0, 0, 0, 0, 0, 0, 0, 0);
         e = exp_q.pop_front();
         checks++;
         if ({btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts} !==
             {e.hit, e.taken, e.target, e.idx, e.lk, e.mp}) begin
            errors++;
            $display("FAIL taken_train[%0d]: got hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d, want hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d",
                     k, btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts,
                     e.hit, e.taken, e.target, e.idx, e.lk, e.mp);
         end
         if (k == 1) begin
            checks++;
            if (btb_hit !== 1'b1) begin
               errors++;
               $display("FAIL btb_fill: got btb_hit=%0b want 1", btb_hit);
            end
         end
         if (k == 10) begin
            checks++;
            if ({pred_idx, pred_taken, pred_target} !== {6'h04, 1'b1, 32'h4000_0080}) begin
               errors++;
               $display("FAIL saturate_taken: got idx=%h tk=%0b tgt=%h want 04 1 40000080",
                        pred_idx, pred_taken, pred_target);
            end
         end
         commit();
      end
   endtask

   task automatic test_not_taken();
      pred_t p;
      for (int k = 0; k < 5; k++) begin
         p = model_pred(32'h4000_0010);
         if (k < 4) drive(1, 32'h4000_0010, 1, 1, 32'h4000_0010, 6'h04, 0, 32'h4000_0014, p.taken, 0);
         else drive(1, 32'h4000_0010, 0, 0, 0, 0, 0, 0, 0, 0);
         e = exp_q.pop_front();
         checks++;
         if ({btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts} !==
             {e.hit, e.taken, e.target, e.idx, e.lk, e.mp}) begin
            errors++;
            $display("FAIL not_taken[%0d]: got hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d, want hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d",
                     k, btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts,
                     e.hit, e.taken, e.target, e.idx, e.lk, e.mp);
         end
         if (k == 4) begin
            checks++;
            if ({btb_hit, pred_taken, pred_target, pred_idx} !== {1'b1, 1'b0, 32'h4000_0014, 6'h04}) begin
               errors++;
               $display("FAIL decay_to_zero: got hit=%0b tk=%0b tgt=%h idx=%h want 1 0 40000014 04",
                        btb_hit, pred_taken, pred_target, pred_idx);
            end
         end
         commit();
      end
   endtask

   task automatic test_jal();
      for (int k = 0; k < 2; k++) begin
         if (k == 0) drive(0, 32'h4000_0020, 1, 0, 32'h4000_0020, 6'h08, 1, 32'h4000_0100, 1, 0);
         else drive(1, 32'h4000_0020, 0, 0, 0, 0, 0, 0, 0, 0);
         e = exp_q.pop_front();
         checks++;
         if ({btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts} !==
             {e.hit, e.taken, e.target, e.idx, e.lk, e.mp}) begin
            errors++;
            $display("FAIL jal[%0d]: got hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d, want hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d",
                     k, btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts,
                     e.hit, e.taken, e.target, e.idx, e.lk, e.mp);
         end
         if (k == 1) begin
            checks++;
            if ({btb_hit, pred_taken, pred_target, pred_idx} !== {1'b1, 1'b1, 32'h4000_0100, 6'h08}) begin
               errors++;
               $display("FAIL jal_predict: got hit=%0b tk=%0b tgt=%h idx=%h want 1 1 40000100 08",
                        btb_hit, pred_taken, pred_target, pred_idx);
            end
         end
         commit();
      end
   endtask

   task automatic test_alias();
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: drive(0, 32'h4000_0010, 1, 1, 32'h4000_0010, 6'h04, 1, 32'h4000_0080, 0, 0);
            1: drive(0, 32'h4000_0090, 1, 1, 32'h4000_0090, 6'h24, 1, 32'h4000_0200, 0, 0);
            2: drive(1, 32'h4000_0010, 0, 0, 0, 0, 0, 0, 0, 0);
            default: drive(1, 32'h4000_0090, 0, 0, 0, 0, 0, 0, 0, 0);
         endcase
         e = exp_q.pop_front();
         checks++;
         if ({btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts} !==
             {e.hit, e.taken, e.target, e.idx, e.lk, e.mp}) begin
            errors++;
            $display("FAIL alias[%0d]: got hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d, want hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d",
                     k, btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts,
                     e.hit, e.taken, e.target, e.idx, e.lk, e.mp);
         end
         if (k >= 2) begin
            checks++;
            if (btb_hit !== (k == 3)) begin
               errors++;
               $display("FAIL alias_hit[%0d]: got btb_hit=%0b want %0b", k, btb_hit, (k == 3));
            end
         end
         commit();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] want_tgt;
      for (int k = 0; k < 2; k++) begin
         drive(1, 32'h4000_0040, k == 0, 0, 32'h4000_0040, 6'h10, 1, 32'h4000_0400, 0, 0);
         e = exp_q.pop_front();
         checks++;
         if ({btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts} !==
             {e.hit, e.taken, e.target, e.idx, e.lk, e.mp}) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d, want hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d",
                     k, btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts,
                     e.hit, e.taken, e.target, e.idx, e.lk, e.mp);
         end
         want_tgt = (k == 0) ? 32'h4000_0044 : 32'h4000_0400;
         checks++;
         if ({btb_hit, pred_taken, pred_target} !== {k == 1, k == 1, want_tgt}) begin
            errors++;
            $display("FAIL read_before_write[%0d]: got hit=%0b tk=%0b tgt=%h want %0b %0b %h",
                     k, btb_hit, pred_taken, pred_target, k == 1, k == 1, want_tgt);
         end
         commit();
      end
   endtask

   task automatic test_stall();
      logic [31:0] lk0, mp0;
      lk0 = m_look; mp0 = m_mis;
      for (int k = 0; k < 7; k++) begin
         if (k < 5) drive(1, 32'h4000_0200, 1, 1, 32'h4000_0200, 6'h00, 1, 32'h4000_0500, 1, 1);
         else drive(1, (k == 5) ? 32'h4000_0200 : 32'h4000_0010, 0, 0, 0, 0, 0, 0, 0, 0);
         e = exp_q.pop_front();
         checks++;
         if ({btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts} !==
             {e.hit, e.taken, e.target, e.idx, e.lk, e.mp}) begin
            errors++;
            $display("FAIL stall[%0d]: got hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d, want hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d",
                     k, btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts,
                     e.hit, e.taken, e.target, e.idx, e.lk, e.mp);
         end
         if (k == 5) begin
            checks++;
            if ({btb_hit, stat_lookups, stat_mispredicts} !== {1'b0, lk0, mp0}) begin
               errors++;
               $display("FAIL stall_freeze: got hit=%0b lk=%0d mp=%0d want 0 %0d %0d",
                        btb_hit, stat_lookups, stat_mispredicts, lk0, mp0);
            end
         end
         commit();
      end
   endtask

   task automatic test_async_reset();
      drive(1, 32'h4000_0020, 0, 0, 0, 0, 0, 0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if ({btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts} !==
          {e.hit, e.taken, e.target, e.idx, e.lk, e.mp}) begin
         errors++;
         $display("FAIL pre_reset: got hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d, want hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d",
                  btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts,
                  e.hit, e.taken, e.target, e.idx, e.lk, e.mp);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts} !==
          {1'b0, 1'b0, 32'h4000_0024, 6'h08, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL async_reset: got hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d, want 0 0 40000024 08 0 0",
                  btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts);
      end
      reset_model();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] pcs [7];
      logic [31:0] lpc, upc;
      pcs[0] = 32'h4000_0010; pcs[1] = 32'h4000_0020; pcs[2] = 32'h4000_0090; pcs[3] = 32'h4000_0040;
      pcs[4] = 32'h4000_0200; pcs[5] = 32'h4000_0300; pcs[6] = 32'hFFFF_FFFC;
      for (int k = 0; k < 400; k++) begin
         lpc = pcs[$urandom_range(0, 6)];
         upc = pcs[$urandom_range(0, 6)];
         drive(1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), upc,
               model_pred(upc).idx, 1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
               1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
         e = exp_q.pop_front();
         checks++;
         if ({btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts} !==
             {e.hit, e.taken, e.target, e.idx, e.lk, e.mp}) begin
            errors++;
            $display("FAIL random[%0d] pc=%h: got hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d, want hit=%0b tk=%0b tgt=%h idx=%h lk=%0d mp=%0d",
                     k, lpc, btb_hit, pred_taken, pred_target, pred_idx, stat_lookups, stat_mispredicts,
                     e.hit, e.taken, e.target, e.idx, e.lk, e.mp);
         end
         commit();
      end
      stall = 1'b0; upd_valid = 1'b0; lookup_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_taken_train();
      test_not_taken();
      test_jal();
      test_alias();
      test_back_to_back();
      test_stall();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
